// File: rtl/lenet_pkg.sv
// Shared constants and types for the LeNet line buffer: ring geometry, pixel type and the fill/stream state.
package lenet_pkg;

    localparam int LB_ROWS       = 5;
    localparam int LB_MEM_ROWS   = 4;
    localparam int LB_DATA_WIDTH = 8;

    typedef logic [LB_DATA_WIDTH-1:0] pixel_t;

    typedef enum logic [0:0] {
        FILL   = 1'b0,
        STREAM = 1'b1
    } lb_state_t;

endpackage

// File: rtl/line_buffer_5row_line_mem.sv
// One image row of storage: 1W/1R synchronous RAM, read-before-write, registered read port.
module line_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 28,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read samples the array before this edge's write lands, so a same-address access returns the old row.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/line_buffer_5row.sv
// Raster-to-column converter: emits rows r-4..r of the current column, one cycle after each pixel.
// Optional frame_done pulse port is built only when LB_FRAME_DONE_EN is defined.
module line_buffer_5row
    import lenet_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28,
    localparam int COL_W     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1,
    localparam int ROW_W     = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] line_0_out,
    output logic [DATA_WIDTH-1:0] line_1_out,
    output logic [DATA_WIDTH-1:0] line_2_out,
    output logic [DATA_WIDTH-1:0] line_3_out,
    output logic [DATA_WIDTH-1:0] line_4_out,
    output logic                  out_valid,
    output logic [COL_W-1:0]      out_col
`ifdef LB_FRAME_DONE_EN
    ,
    output logic                  frame_done
`endif
);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_PRIME = ROW_W'(LB_MEM_ROWS - 1);

    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [1:0]            slot_q, slot_d;
    lb_state_t             state_q, state_d;
    logic [1:0]            rd_base_q;
    logic [DATA_WIDTH-1:0] line4_q;
    logic                  out_valid_q;
    logic [COL_W-1:0]      out_col_q;
    logic                  accept;
    logic                  last_col;
    logic                  last_row;

    logic [DATA_WIDTH-1:0] rd_data  [LB_MEM_ROWS];
    logic [DATA_WIDTH-1:0] line_mux [LB_ROWS-1];

    assign accept   = in_valid && !rst;
    assign last_col = (col_q == COL_LAST);
    assign last_row = (row_q == ROW_LAST);

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        slot_d  = slot_q;
        state_d = state_q;
        if (in_valid) begin
            if (last_col) begin
                col_d = '0;
                if (last_row) begin
                    row_d   = '0;
                    slot_d  = '0;
                    state_d = FILL;
                end else begin
                    row_d  = row_q + 1'b1;
                    slot_d = slot_q + 2'd1;
                    if (row_q == ROW_PRIME) begin
                        state_d = STREAM;
                    end
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            slot_q      <= '0;
            state_q     <= FILL;
            rd_base_q   <= '0;
            line4_q     <= '0;
            out_valid_q <= 1'b0;
            out_col_q   <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            slot_q      <= slot_d;
            state_q     <= state_d;
            out_valid_q <= in_valid && (state_q == STREAM);
            if (in_valid) begin
                rd_base_q <= slot_q;
                line4_q   <= in_data;
                out_col_q <= col_q;
            end
        end
    end

    // Each row memory is read every accepted pixel; only the slot being refilled is written.
    generate
        for (genvar gi = 0; gi < LB_MEM_ROWS; gi++) begin : g_mem
            line_mem #(
                .DATA_WIDTH(DATA_WIDTH),
                .DEPTH     (IMG_WIDTH)
            ) u_line_mem (
                .clk    (clk),
                .rst    (rst),
                .we_i   (accept && (slot_q == 2'(gi))),
                .re_i   (accept),
                .addr_i (col_q),
                .wdata_i(in_data),
                .rdata_o(rd_data[gi])
            );
        end
    endgenerate

    // The slot being overwritten still holds the oldest row (r-4); the following slots age forward to r-1.
    generate
        for (genvar gi = 0; gi < LB_ROWS - 1; gi++) begin : g_mux
            localparam logic [1:0] OFS = 2'(gi);
            assign line_mux[gi] = rd_data[rd_base_q + OFS];
        end
    endgenerate

    assign line_0_out = line_mux[0];
    assign line_1_out = line_mux[1];
    assign line_2_out = line_mux[2];
    assign line_3_out = line_mux[3];
    assign line_4_out = line4_q;
    assign out_valid  = out_valid_q;
    assign out_col    = out_col_q;

`ifdef LB_FRAME_DONE_EN
    logic frame_done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= in_valid && (state_q == STREAM) && last_col && last_row;
        end
    end

    assign frame_done = frame_done_q;
`endif

endmodule

// File: tb/tb_line_buffer_5row.sv
// Self-checking bench for line_buffer_5row on an 8x8 image: directed raster steps plus random frames.
module tb_line_buffer_5row;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [DW-1:0] line_0_out, line_1_out, line_2_out, line_3_out, line_4_out;
    logic          out_valid;
    logic [2:0]    out_col;
`ifdef LB_FRAME_DONE_EN
    logic          frame_done;
`endif

    line_buffer_5row #(
        .DATA_WIDTH(DW),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .line_0_out(line_0_out),
        .line_1_out(line_1_out),
        .line_2_out(line_2_out),
        .line_3_out(line_3_out),
        .line_4_out(line_4_out),
        .out_valid (out_valid),
        .out_col   (out_col)
`ifdef LB_FRAME_DONE_EN
        ,
        .frame_done(frame_done)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the image as written so far plus the raster position of the next pixel.
    logic [DW-1:0] img [H][W];
    int            m_row = 0;
    int            m_col = 0;
    logic [DW-1:0] last_lines [5];
    bit            last_ok = 1'b0;
    int            fd_count = 0;
    logic [DW-1:0] lines_o [5];

    assign lines_o[0] = line_0_out;
    assign lines_o[1] = line_1_out;
    assign lines_o[2] = line_2_out;
    assign lines_o[3] = line_3_out;
    assign lines_o[4] = line_4_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic px(input logic [DW-1:0] d);
        bit            v;
        bit            fd_exp;
        int            c;
        int            r;
        logic [DW-1:0] e [5];
        in_valid = 1'b1;
        in_data  = d;
        r = m_row;
        c = m_col;
        img[r][c] = d;
        v = (r >= 4);
        fd_exp = (r == H - 1) && (c == W - 1);
        for (int k = 0; k < 5; k++) begin
            e[k] = v ? img[r - 4 + k][c] : '0;
        end
        m_col++;
        if (m_col == W) begin
            m_col = 0;
            m_row = (m_row == H - 1) ? 0 : m_row + 1;
        end
        @(posedge clk);
        #1;
        $display("px r=%0d c=%0d d=%02h valid=%0b lines=%02h %02h %02h %02h %02h col=%0d",
                 r, c, d, out_valid, line_0_out, line_1_out, line_2_out, line_3_out, line_4_out, out_col);
        check($sformatf("out_valid(%0d,%0d)", r, c), 32'(out_valid), 32'(v));
        if (v) begin
            for (int k = 0; k < 5; k++) begin
                check($sformatf("line_%0d(%0d,%0d)", k, r, c), 32'(lines_o[k]), 32'(e[k]));
                last_lines[k] = e[k];
            end
            check($sformatf("out_col(%0d,%0d)", r, c), 32'(out_col), 32'(c));
        end
        last_ok = v;
`ifdef LB_FRAME_DONE_EN
        check($sformatf("frame_done(%0d,%0d)", r, c), 32'(frame_done), 32'(fd_exp));
        if (frame_done === 1'b1) fd_count++;
`endif
    endtask

    task automatic px_pat();
        px(DW'(m_row * 16 + m_col));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            $display("idle %0d valid=%0b lines=%02h %02h %02h %02h %02h",
                     i, out_valid, line_0_out, line_1_out, line_2_out, line_3_out, line_4_out);
            check("idle_out_valid", 32'(out_valid), 32'd0);
            if (last_ok) begin
                for (int k = 0; k < 5; k++) begin
                    check($sformatf("idle_hold_line_%0d", k), 32'(lines_o[k]), 32'(last_lines[k]));
                end
            end
`ifdef LB_FRAME_DONE_EN
            check("idle_frame_done", 32'(frame_done), 32'd0);
`endif
        end
    endtask

    task automatic do_reset(input logic with_valid, input logic [DW-1:0] d);
        rst      = 1'b1;
        in_valid = with_valid;
        in_data  = d;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        $display("reset valid_in=%0b valid=%0b lines=%02h %02h %02h %02h %02h col=%0d",
                 with_valid, out_valid, line_0_out, line_1_out, line_2_out, line_3_out, line_4_out, out_col);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rst_line_%0d", k), 32'(lines_o[k]), 32'd0);
        end
        check("rst_out_col", 32'(out_col), 32'd0);
`ifdef LB_FRAME_DONE_EN
        check("rst_frame_done", 32'(frame_done), 32'd0);
`endif
        m_row   = 0;
        m_col   = 0;
        last_ok = 1'b0;
    endtask

    task automatic chk5(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] c, input logic [DW-1:0] d, input logic [DW-1:0] e);
        check({tag, "_l0"}, 32'(line_0_out), 32'(a));
        check({tag, "_l1"}, 32'(line_1_out), 32'(b));
        check({tag, "_l2"}, 32'(line_2_out), 32'(c));
        check({tag, "_l3"}, 32'(line_3_out), 32'(d));
        check({tag, "_l4"}, 32'(line_4_out), 32'(e));
    endtask

    initial begin
        // Step 1: reset, then rows 0..3 up to (3,6) never flag a valid column.
        do_reset(1'b0, '0);
        for (int i = 0; i < 31; i++) px_pat();

        // Step 2: (3,7) completes the fill, (4,3) is the first checked column of interest.
        for (int i = 0; i < 5; i++) px_pat();
        chk5("t2", 8'h03, 8'h13, 8'h23, 8'h33, 8'h43);
        check("t2_col", 32'(out_col), 32'd3);
        check("t2_valid", 32'(out_valid), 32'd1);

        // Step 3: stall mid row 6, then resume at (6,5).
        for (int i = 0; i < 17; i++) px_pat();
        idle(5);
        px_pat();
        chk5("t3", 8'h25, 8'h35, 8'h45, 8'h55, 8'h65);

        // Step 6: last pixel of the frame, then the next frame starts in FILL.
        for (int i = 0; i < 9; i++) px_pat();
        px_pat();
        chk5("t6", 8'h37, 8'h47, 8'h57, 8'h67, 8'h77);

        // Step 4: two random frames back-to-back; the second one has random stalls.
        for (int i = 0; i < W * H; i++) px(DW'($urandom));
        for (int i = 0; i < W * H; i++) begin
            px(DW'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
`ifdef LB_FRAME_DONE_EN
        check("frame_done_count", 32'(fd_count), 32'd3);
`endif

        // Step 5: reset together with a valid pixel at (5,2), then a fresh frame.
        for (int i = 0; i < 42; i++) px_pat();
        do_reset(1'b1, 8'h52);
        for (int i = 0; i < 36; i++) px_pat();
        chk5("t5", 8'h03, 8'h13, 8'h23, 8'h33, 8'h43);
        check("t5_col", 32'(out_col), 32'd3);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
